// File: rtl/hangy_pkg.sv
// Shared letter encoding and key front-end state type for the hangman game.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Letter codes 0..25 map to 'A'..'Z'; the game controller imports the same
// constants so the encoding lives in exactly one place.
package hangy_pkg;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    OFFER,
    WAIT_RELEASE
  } keystate_t;

endpackage

// File: rtl/hangy_debounce.sv
// Button synchroniser, debouncer and rising-edge detector.
// Latency: raw edge to level/rise change = 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; rise is a free-running 1-cycle pulse.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   raw        : asynchronous button level from the pad
//   level      : debounced button level
//   rise       : 1-cycle pulse coincident with level going 0->1
module hangy_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreement restarts it, so a glitch shorter than
  // DEBOUNCE_CYCLES never reaches CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hangy_key_frontend.sv
// Turns raw guess button + letter switches into single-shot guess events.
// Latency: debounced press -> out_valid 2 cycles; handshake -> out_next 1 cycle.
// Backpressure: guess held in OFFER while out_ready=0; presses outside IDLE dropped.
//
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   btn_raw        : asynchronous guess button (1 = pressed)
//   char_raw       : asynchronous letter switches
//   clear_history  : new-game pulse, clears guessed-letter history
//   out_valid/out_ready/out_char : guess handshake, out_char stable while valid
//   out_next       : 1-cycle pulse the cycle after a completed handshake
//   err_invalid    : 1-cycle pulse, pressed with an out-of-range letter code
//   err_repeat     : 1-cycle pulse, letter already guessed
//   busy           : high whenever the FSM is not IDLE
//
// Optional feature macro REPEAT_FILTER_EN: keeps a per-letter history and
// rejects repeats. Without it err_repeat stays 0 and clear_history is ignored.
module hangy_key_frontend
  import hangy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CHAR_W          = hangy_pkg::LETTER_W,
  parameter int NUM_LETTERS     = hangy_pkg::NUM_LETTERS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic [CHAR_W-1:0] char_raw,
  input  logic              clear_history,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_next,
  output logic              err_invalid,
  output logic              err_repeat,
  output logic              busy
);

  localparam logic [CHAR_W-1:0] LAST_CODE = CHAR_W'(NUM_LETTERS - 1);

  logic              btn_level;
  logic              press;
  logic [CHAR_W-1:0] char_s1;
  logic [CHAR_W-1:0] char_s2;
  logic              hist_hit;
  keystate_t         state;

  hangy_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_raw),
    .level (btn_level),
    .rise  (press)
  );

  // The switches are only sampled DEBOUNCE_CYCLES after the button moved, so
  // a plain per-bit 2-flop synchroniser is enough: any skew between bits has
  // long settled by the time the press arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      char_s1 <= '0;
      char_s2 <= '0;
    end else begin
      char_s1 <= char_raw;
      char_s2 <= char_s1;
    end
  end

`ifdef REPEAT_FILTER_EN
  logic [NUM_LETTERS-1:0] history;

  // Clear has priority over a same-cycle handshake so a new game always
  // starts with an empty history. Only legal codes ever reach OFFER, so the
  // write index is always in range.
  always_ff @(posedge clk) begin
    if (reset || clear_history) begin
      history <= '0;
    end else if (state == OFFER && out_valid && out_ready) begin
      history[out_char] <= 1'b1;
    end
  end

  // Only consulted after the range check has passed.
  assign hist_hit = history[out_char];
`else
  logic unused_clear_history;

  assign unused_clear_history = clear_history;
  assign hist_hit             = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_char    <= '0;
      out_next    <= 1'b0;
      err_invalid <= 1'b0;
      err_repeat  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      out_next    <= 1'b0;
      err_invalid <= 1'b0;
      err_repeat  <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            out_char <= char_s2;
            state    <= CAPTURE;
            busy     <= 1'b1;
          end
        end
        CAPTURE: begin
          if (out_char > LAST_CODE) begin
            err_invalid <= 1'b1;
            state       <= WAIT_RELEASE;
          end else if (hist_hit) begin
            err_repeat <= 1'b1;
            state      <= WAIT_RELEASE;
          end else begin
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          // Button release is ignored here: an accepted press is never lost.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_next  <= 1'b1;
            state     <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!btn_level) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hangy_key_frontend.sv
module tb_hangy_key_frontend;

  localparam int DEB      = 4;
  localparam int EV_OFFER = 0;
  localparam int EV_INV   = 1;
  localparam int EV_REP   = 2;

  logic       clk           = 1'b0;
  logic       reset         = 1'b1;
  logic       btn_raw       = 1'b0;
  logic [4:0] char_raw      = 5'd0;
  logic       clear_history = 1'b0;
  logic       out_ready     = 1'b1;
  logic       out_valid;
  logic [4:0] out_char;
  logic       out_next;
  logic       err_invalid;
  logic       err_repeat;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [4:0] ch;
  } ev_t;

  ev_t exp_q[$];

  hangy_key_frontend #(
    .DEBOUNCE_CYCLES(DEB),
    .CHAR_W         (5),
    .NUM_LETTERS    (26)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .char_raw     (char_raw),
    .clear_history(clear_history),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_char     (out_char),
    .out_next     (out_next),
    .err_invalid  (err_invalid),
    .err_repeat   (err_repeat),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [4:0] ch);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [4:0] ch);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d char %0d, expected no event", kind, ch);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_char", {27'd0, ch}, {27'd0, e.ch});
    end
  endtask

  // Monitor: pops the scoreboard on every observed event, and checks the
  // out_next pulse and OFFER hold behaviour cycle by cycle.
  logic       prev_hs   = 1'b0;
  logic       prev_hold = 1'b0;
  logic [4:0] prev_char = 5'd0;

  always @(negedge clk) begin
    if (reset) begin
      prev_hs   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("out_next_follows_handshake", out_next, prev_hs);
      if (prev_hold) begin
        chk("offer_valid_held", out_valid, 1);
        chk("offer_char_held", out_char, prev_char);
      end
      if (out_valid && out_ready) pop_cmp(EV_OFFER, out_char);
      if (err_invalid)            pop_cmp(EV_INV, out_char);
      if (err_repeat)             pop_cmp(EV_REP, out_char);
      prev_hs   = out_valid && out_ready;
      prev_hold = out_valid && !out_ready;
      prev_char = out_char;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw edge -> press takes 2+DEB edges, then CAPTURE and OFFER/err: 8 edges.
  task automatic press_wait(input logic [4:0] ch, input string name);
    int n;
    n        = 0;
    char_raw = ch;
    btn_raw  = 1'b1;
    while (!(out_valid || err_invalid || err_repeat) && n < 40) begin
      tick(1);
      n++;
    end
    chk(name, n, 2 + DEB + 2);
  endtask

  task automatic release_settle(input string name);
    btn_raw = 1'b0;
    tick(12);
    chk(name, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    tick(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_out_next", out_next, 0);
    chk("rst_err_invalid", err_invalid, 0);
    chk("rst_err_repeat", err_repeat, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick(2);

    // 1: normal press of letter 7
    push_ev(EV_OFFER, 5'd7);
    press_wait(5'd7, "t1_latency");
    tick(2);
    chk("t1_busy_while_held", busy, 1);
    release_settle("t1_busy_after_release");

    // 2: 2-cycle glitch must be ignored
    btn_raw = 1'b1;
    tick(2);
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (busy !== 1'b0 || out_valid !== 1'b0) chk("t2_glitch_quiet", {busy, out_valid}, 0);
    end
    chk("t2_busy", busy, 0);
    chk("t2_out_valid", out_valid, 0);

    // 3: out-of-range letter
    push_ev(EV_INV, 5'd27);
    press_wait(5'd27, "t3_latency");
    chk("t3_no_valid", out_valid, 0);
    tick(2);
    release_settle("t3_busy_after_release");

    // 4: backpressure with release during OFFER
    out_ready = 1'b0;
    press_wait(5'd3, "t4_latency");
    tick(2);
    btn_raw = 1'b0;
    tick(20);
    chk("t4_valid_held", out_valid, 1);
    chk("t4_char_held", out_char, 3);
    chk("t4_busy_held", busy, 1);
    push_ev(EV_OFFER, 5'd3);
    out_ready = 1'b1;
    tick(1);
    chk("t4_valid_dropped", out_valid, 0);
    chk("t4_next_pulse", out_next, 1);
    tick(1);
    chk("t4_next_single", out_next, 0);
    release_settle("t4_busy_after_release");

    // 5: repeat letter, then clear history
    push_ev(EV_OFFER, 5'd5);
    press_wait(5'd5, "t5a_latency");
    tick(2);
    release_settle("t5a_busy");
`ifdef REPEAT_FILTER_EN
    push_ev(EV_REP, 5'd5);
`else
    push_ev(EV_OFFER, 5'd5);
`endif
    press_wait(5'd5, "t5b_latency");
    tick(2);
    release_settle("t5b_busy");
    clear_history = 1'b1;
    tick(1);
    clear_history = 1'b0;
    push_ev(EV_OFFER, 5'd5);
    press_wait(5'd5, "t5c_latency");
    tick(2);
    release_settle("t5c_busy");

    // 6: reset in OFFER, held button re-presses after the debounce interval
    out_ready = 1'b0;
    press_wait(5'd9, "t6_latency");
    reset = 1'b1;
    tick(1);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_char", out_char, 0);
    chk("t6_rst_out_next", out_next, 0);
    chk("t6_rst_err_invalid", err_invalid, 0);
    chk("t6_rst_err_repeat", err_repeat, 0);
    chk("t6_rst_busy", busy, 0);
    reset = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick(1);
      n++;
    end
    chk("t6_repress_latency", n, 2 + DEB + 2);
    push_ev(EV_OFFER, 5'd9);
    out_ready = 1'b1;
    tick(1);
    chk("t6_next_pulse", out_next, 1);
    release_settle("t6_busy_after_release");

    tick(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
